// File: rtl/bus_pkg.sv
// Shared definitions for the data bus master: funct3 size codes, FSM states,
// and the lane helpers used for stores and alignment checks.
package bus_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} size_e;

  // Collapse funct3 into an access size; unsupported codes behave as words.
  function automatic size_e size_of(input logic [2:0] f3);
    case (f3)
      SZ_B, SZ_BU: size_of = SIZE_B;
      SZ_H, SZ_HU: size_of = SIZE_H;
      SZ_W:        size_of = SIZE_W;
      default:     size_of = SIZE_W;
    endcase
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (size_of(f3))
      SIZE_B:  lane_mask = 4'b0001 << off;
      SIZE_H:  lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the enabled lanes carry the payload.
  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] w);
    case (size_of(f3))
      SIZE_B:  lane_data = {4{w[7:0]}};
      SIZE_H:  lane_data = {2{w[15:0]}};
      default: lane_data = w;
    endcase
  endfunction

  // Halfwords need even addresses, words need 4-byte alignment.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (size_of(f3))
      SIZE_H:  misaligned = off[0];
      SIZE_W:  misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Extracts the addressed byte/halfword from the bus word and sign- or
// zero-extends it according to funct3.
module load_extender
  import bus_pkg::*;
(
  input  logic [31:0] prdata,
  input  logic [1:0]  off,
  input  logic [2:0]  strb,
  output logic [31:0] ext
);

  logic [31:0] shifted;

  // Align the addressed lane to bit 0, then extend by size and signedness.
  always_comb begin
    shifted = prdata >> {off, 3'b000};
    case (size_of(strb))
      SIZE_B:  ext = strb[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  ext = strb[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = prdata;
    endcase
  end

endmodule

// File: rtl/data_bus_master.sv
// APB-style bus master for loads/stores issued by the multicycle control
// unit. One transfer at a time: IDLE -> SETUP -> ACCESS -> RESP, with a
// misaligned request skipping straight to RESP and a watchdog on PREADY.
module data_bus_master
  import bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busWe,
  input  logic              busRe,
  input  logic [2:0]        strb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] PADDR,
  output logic [31:0]       PWDATA,
  output logic [3:0]        PSTRB,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  state_e           state, next;
  logic             req, bad;
  logic [1:0]       off;
  logic [2:0]       size_code;
  logic             err_r;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      ext;

  assign req = busWe | busRe;
  assign bad = misaligned(strb, addr[1:0]);

  load_extender u_ext (
    .prdata (PRDATA),
    .off    (off),
    .strb   (size_code),
    .ext    (ext)
  );

  // State register; reset drops the bus strobes immediately via the decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    next    = state;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    busy    = (state != S_IDLE) | req;
    case (state)
      S_IDLE: begin
        if (req) next = bad ? S_RESP : S_SETUP;
      end
      S_SETUP: begin
        PSEL = 1'b1;
        next = S_ACCESS;
      end
      S_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || cnt == LAST) next = S_RESP;
      end
      S_RESP: begin
        done = 1'b1;
        err  = err_r;
        next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  // Request latch, watchdog counter and load-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PWRITE    <= 1'b0;
      off       <= '0;
      size_code <= '0;
      err_r     <= 1'b0;
      cnt       <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            PADDR     <= {addr[ADDR_W-1:2], 2'b00};
            PWDATA    <= lane_data(strb, wdata);
            PSTRB     <= busWe ? lane_mask(strb, addr[1:0]) : 4'b0000;
            PWRITE    <= busWe;
            off       <= addr[1:0];
            size_code <= strb;
            err_r     <= bad;
            cnt       <= '0;
          end
        end
        S_ACCESS: begin
          if (PREADY) begin
            err_r <= 1'b0;
            if (!PWRITE) rdata <= ext;
          end else if (cnt == LAST) begin
            err_r <= 1'b1;
            if (!PWRITE) rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_master.sv
// Directed bench for data_bus_master with a per-cycle reference model.
module tb_data_bus_master;

  localparam int TIMEOUT = 16;

  logic        clk = 0;
  logic        reset = 1;
  logic        busWe = 0, busRe = 0;
  logic [2:0]  strb = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] rdata;
  logic        busy, done, err;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA = 0;
  logic        PREADY = 0;

  data_bus_master #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .busWe(busWe), .busRe(busRe), .strb(strb),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .err(err), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access width in bytes from funct3.
  function automatic int nbytes(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] f, input int off);
    return (off % nbytes(f)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f, input int off);
    logic [3:0] r = 0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + nbytes(f)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_pwdata(input logic [2:0] f, input logic [31:0] w);
    logic [31:0] r = 0;
    int n = nbytes(f);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input int off, input logic [31:0] d);
    int unsigned v = d >> (8 * off);
    int n = nbytes(f);
    if (n == 4) return d;
    if (n == 1) begin
      v = v % 256;
      if (!f[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = v % 65536;
      if (!f[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Expected outputs for the current cycle, set by the stimulus process.
  logic        chk_en = 0;
  logic        e_busy, e_psel, e_pen, e_done, e_err, e_pwrite;
  logic [31:0] e_paddr, e_pwdata, m_rdata = 0;
  logic [3:0]  e_pstrb;

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", busy, e_busy);
      cmp("psel", PSEL, e_psel);
      cmp("penable", PENABLE, e_pen);
      cmp("done", done, e_done);
      cmp("err", err, e_err);
      cmp("rdata", rdata, m_rdata);
      if (e_psel) begin
        cmp("paddr", PADDR, e_paddr);
        cmp("pwrite", PWRITE, e_pwrite);
        cmp("pstrb", PSTRB, e_pstrb);
        if (e_pwrite) cmp("pwdata", PWDATA, e_pwdata);
      end
    end
  end

  int          seen_done, pen_cnt;
  logic        seen_err;
  logic [31:0] seen_pwdata, seen_paddr;
  logic [3:0]  seen_pstrb;

  // One transfer; waits >= TIMEOUT means the slave never answers.
  task automatic xfer(input bit we, input bit re, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] w, input logic [31:0] prd, input int waits);
    int  off = a[1:0];
    bit  mis = m_mis(f, off);
    bit  to  = waits >= TIMEOUT;
    int  resp = mis ? 1 : (to ? 2 + TIMEOUT : 3 + waits);
    seen_done = -1; seen_err = 0; pen_cnt = 0;
    @(posedge clk); #1;
    busWe = we; busRe = re; strb = f; addr = a; wdata = w; PRDATA = prd;
    for (int k = 0; k <= resp + 1; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        busWe = 0; busRe = 0;
      end
      PREADY   = !mis && !to && k >= 2 + waits && k < resp;
      e_busy   = k <= resp;
      e_psel   = !mis && k >= 1 && k < resp;
      e_pen    = !mis && k >= 2 && k < resp;
      e_done   = k == resp;
      e_err    = (k == resp) && (mis || to);
      e_paddr  = {a[31:2], 2'b00};
      e_pwrite = we;
      e_pstrb  = we ? m_strb(f, off) : 4'b0000;
      e_pwdata = m_pwdata(f, w);
      if (k == resp && !we && !mis) m_rdata = to ? 32'h0 : m_load(f, off, prd);
      chk_en = 1;
      @(negedge clk);
      if (PSEL && !PENABLE) begin
        seen_pstrb = PSTRB; seen_pwdata = PWDATA; seen_paddr = PADDR;
      end
      if (PENABLE) pen_cnt++;
      if (done) begin seen_done = k; seen_err = err; end
    end
    PREADY = 0;
  endtask

  localparam logic [31:0] PD = 32'h80FF_7F01;

  initial begin
    int ndone;
    // Outputs while reset is held.
    @(negedge clk);
    cmp("rst_rdata", rdata, 0);   cmp("rst_busy", busy, 0);
    cmp("rst_done", done, 0);     cmp("rst_err", err, 0);
    cmp("rst_paddr", PADDR, 0);   cmp("rst_pwdata", PWDATA, 0);
    cmp("rst_pstrb", PSTRB, 0);   cmp("rst_pwrite", PWRITE, 0);
    cmp("rst_psel", PSEL, 0);     cmp("rst_penable", PENABLE, 0);
    @(posedge clk); #1 reset = 0;

    xfer(1, 0, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 0, 0);
    cmp("sw_done_cycle", seen_done, 3);
    cmp("sw_err", seen_err, 0);
    cmp("sw_paddr", seen_paddr, 32'h1000_0004);
    cmp("sw_pstrb", seen_pstrb, 4'b1111);
    cmp("sw_access_cycles", pen_cnt, 1);

    xfer(1, 0, 3'b000, 32'h1000_0003, 32'h0000_00A5, 0, 0);
    cmp("sb_pwdata", seen_pwdata, 32'hA5A5_A5A5);
    cmp("sb_pstrb", seen_pstrb, 4'b1000);

    xfer(1, 0, 3'b001, 32'h2000_0002, 32'h1234_BEEF, 0, 1);
    cmp("sh_pwdata", seen_pwdata, 32'hBEEF_BEEF);
    cmp("sh_pstrb", seen_pstrb, 4'b1100);

    xfer(0, 1, 3'b000, 32'h3000_0003, PD, PD, 0);
    cmp("lb_rdata", rdata, 32'hFFFF_FF80);
    xfer(0, 1, 3'b100, 32'h3000_0003, 0, PD, 0);
    cmp("lbu_rdata", rdata, 32'h0000_0080);
    xfer(0, 1, 3'b001, 32'h3000_0002, 0, PD, 0);
    cmp("lh_rdata", rdata, 32'hFFFF_80FF);
    xfer(0, 1, 3'b101, 32'h3000_0000, 0, PD, 0);
    cmp("lhu_rdata", rdata, 32'h0000_7F01);

    xfer(0, 1, 3'b010, 32'h3000_0008, 0, 32'h1357_9BDF, 5);
    cmp("ws_done_cycle", seen_done, 8);
    cmp("ws_access_cycles", pen_cnt, 6);
    cmp("ws_rdata", rdata, 32'h1357_9BDF);

    // Both strobes: the store wins and rdata is untouched.
    xfer(1, 1, 3'b010, 32'h4000_0010, 32'hCAFE_F00D, 32'h1111_1111, 0);
    cmp("both_rdata_kept", rdata, 32'h1357_9BDF);

    // Unsupported codes act as words.
    xfer(1, 0, 3'b111, 32'h4000_0020, 32'h0BAD_F00D, 0, 0);
    cmp("f111_pstrb", seen_pstrb, 4'b1111);
    xfer(0, 1, 3'b011, 32'h4000_0024, 0, 32'h89AB_CDEF, 2);
    cmp("f011_rdata", rdata, 32'h89AB_CDEF);

    // Write timeout leaves rdata alone; read timeout clears it.
    xfer(1, 0, 3'b010, 32'h5000_0000, 32'h1, 0, 99);
    cmp("wto_err", seen_err, 1);
    cmp("wto_rdata", rdata, 32'h89AB_CDEF);
    xfer(0, 1, 3'b010, 32'h5000_0004, 0, 32'hFFFF_FFFF, 99);
    cmp("rto_done_cycle", seen_done, 2 + TIMEOUT);
    cmp("rto_access_cycles", pen_cnt, TIMEOUT);
    cmp("rto_err", seen_err, 1);
    cmp("rto_rdata", rdata, 0);

    // Misaligned requests never touch the bus.
    xfer(0, 1, 3'b100, 32'h6000_0001, 0, PD, 0);
    xfer(0, 1, 3'b010, 32'h6000_0002, 0, 32'h2222_2222, 0);
    cmp("mis_lw_done_cycle", seen_done, 1);
    cmp("mis_lw_err", seen_err, 1);
    cmp("mis_lw_access_cycles", pen_cnt, 0);
    cmp("mis_lw_rdata_kept", rdata, 32'h0000_007F);
    xfer(1, 0, 3'b001, 32'h6000_0001, 32'h3333, 0, 0);
    cmp("mis_sh_err", seen_err, 1);

    // Reset during ACCESS.
    chk_en = 0;
    @(posedge clk); #1;
    busRe = 1; strb = 3'b010; addr = 32'h7000_0040; PREADY = 0;
    @(posedge clk); #1 busRe = 0;
    @(posedge clk); #1;
    cmp("pre_rst_penable", PENABLE, 1);
    #2 reset = 1;
    #1;
    cmp("arst_psel", PSEL, 0);
    cmp("arst_penable", PENABLE, 0);
    cmp("arst_busy", busy, 0);
    @(posedge clk); #1 reset = 0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    cmp("arst_no_done", ndone, 0);
    cmp("arst_rdata", rdata, 0);
    m_rdata = 0;

    xfer(0, 1, 3'b000, 32'h7000_0001, 0, PD, 0);
    cmp("post_rst_lb", rdata, 32'h0000_007F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
